alu_mult_seq: RTL and testbench
===============================

# alu_mult_seq

Multi-cycle multiply sequencer that drives the shared 32-bit ALU (`alu_main`) to compute a 32x32 -> 64-bit product by iterative shift-and-add, one ALU ADD per cycle. It sits beside the ALU in the MIPS datapath and services `mult`/`multu`. It owns the ALU operand and select lines while busy and leaves the result in HI/LO registers. Start/busy/done handshake toward the main controller.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `CNT_W`, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `op_a`  in  WIDTH  multiplicand (rs), captured on accepted start.
- `op_b`  in  WIDTH  multiplier (rt), captured on accepted start.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle pulse; HI/LO valid.
- `hi`  out  WIDTH  upper product word.
- `lo`  out  WIDTH  lower product word.
- `alu_a`  out  WIDTH  ALU input A; equals HI register.
- `alu_b`  out  WIDTH  ALU input B; equals captured multiplicand.
- `alu_sel`  out  3  3'b010 (ADD) in RUN, 3'b000 (AND) otherwise.
- `alu_result`  in  WIDTH  combinational ALU result, same cycle.

## Operation
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, multiplicand=0, counter=0, `alu_sel`=3'b000.
- IDLE: on `start`=1: MCAND<=op_a, LO<=op_b, HI<=0, counter<=0, -> RUN. Otherwise hold; HI/LO keep the last product.
- RUN, each cycle: if LO[0]=1, sum=`alu_result`, carry=(sum < HI, unsigned); else sum=HI, carry=0. Then {HI,LO} <= {carry,sum,LO} >> 1; counter++. After iteration WIDTH-1 (counter==WIDTH-1) -> DONE, or -> FIXUP when `MULT_SIGNED_EN` is defined.
- FIXUP (only with `MULT_SIGNED_EN`): if the sign flag is set, {HI,LO} <= two's complement of {HI,LO} using an internal 64-bit negate (not the ALU). -> DONE.
- DONE: `done`=1 for exactly this cycle. -> IDLE.
- `start` in RUN, FIXUP or DONE is ignored and not queued.
- Arithmetic is unsigned modulo 2^(2*WIDTH). The product is exact: no overflow is possible.

## Timing
- Start accepted at edge E0. RUN occupies the cycles after edges E0..E(WIDTH-1). DONE is the cycle after edge E(WIDTH), or E(WIDTH+1) when signed.
- Latency from start to done: WIDTH+1 cycles (33) unsigned, WIDTH+2 (34) signed. Back-to-back throughput is one op per WIDTH+2 or WIDTH+3 cycles, because DONE returns to IDLE before the next start.
- `busy` rises the cycle after an accepted start and falls the cycle after `done`.
- HI/LO are intermediate during RUN and FIXUP. They are valid from the `done` cycle until the next accepted start.
- Reset mid-operation: immediate return to IDLE with all outputs zeroed. There is no `done` for the aborted op.
- `alu_a`/`alu_b` change only on clock edges. `alu_result` must settle within one cycle.

## Configuration
- `MULT_SIGNED_EN` defined:
  - At start, op_a and op_b are replaced by their magnitudes (two's complement if MSB=1).
  - sign flag = op_a[MSB] ^ op_b[MSB].
  - FIXUP state is present; result is the signed 64-bit product.
  - Magnitude of 0x80000000 is 0x80000000 interpreted unsigned; the result stays correct.
- Not defined:
  - Operands are used as-is and there is no FIXUP state.
  - Result is the unsigned product (`multu` semantics).

## Test plan
- Basic: op_a=3, op_b=5, start pulse -> `done` exactly 33 cycles later (unsigned build); hi=0, lo=15; `alu_sel`=3'b010 on each of the 32 RUN cycles.
- Carry path: op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Zero operand: op_a=0x12345678, op_b=0 -> hi=0, lo=0; `done` still at 33 cycles.
- Ignored start: start re-asserted with op_a=7 on cycle 10 of RUN -> result unaffected (3x5=15); no second `done`.
- Reset mid-op: assert `reset` at RUN cycle 16 -> `busy`=0, hi=lo=0 asynchronously; no `done`; a new start afterwards completes normally.
- Signed (`MULT_SIGNED_EN`): op_a=0xFFFFFFFE (-2), op_b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, `done` at 34 cycles. Also op_a=op_b=0x80000000 -> hi=0x40000000, lo=0.

Source files
------------

// File: rtl/alu_mult_seq.sv
// Sequential shift-and-add multiplier that drives the shared ALU with one ADD per cycle.
// Optional signed (mult) support is enabled by defining MULT_SIGNED_EN; the default build is multu.
module alu_mult_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int unsigned PW      = 2 * WIDTH;
  localparam logic [2:0]  SEL_ADD = 3'b010;
  localparam logic [2:0]  SEL_AND = 3'b000;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

`ifdef MULT_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_alu_sel;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [2:0]       w_sel_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_cap_a;
  logic [WIDTH-1:0] w_cap_b;
`ifdef MULT_SIGNED_EN
  logic             r_sign;
  logic [PW-1:0]    w_neg;
`endif

  assign w_last = (r_cnt == LAST_ITER);

  // Operand capture: magnitudes in the signed build, raw values otherwise
`ifdef MULT_SIGNED_EN
  assign w_cap_a = op_a[WIDTH-1] ? (WIDTH'(0) - op_a) : op_a;
  assign w_cap_b = op_b[WIDTH-1] ? (WIDTH'(0) - op_b) : op_b;
  assign w_neg   = PW'(0) - {r_hi, r_lo};
`else
  assign w_cap_a = op_a;
  assign w_cap_b = op_b;
`endif

  // One iteration: add the multiplicand when the current multiplier bit is set
  always_comb begin
    w_sum   = r_hi;
    w_carry = 1'b0;
    if (r_lo[0]) begin
      w_sum   = alu_result;
      w_carry = (alu_result < r_hi);
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
`ifdef MULT_SIGNED_EN
        if (w_last) w_state_nxt = S_FIXUP;
`else
        if (w_last) w_state_nxt = S_DONE;
`endif
      end
`ifdef MULT_SIGNED_EN
      S_FIXUP: w_state_nxt = S_DONE;
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so the handshake and ALU select are registered
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_sel_nxt  = SEL_AND;
    if (w_state_nxt != S_IDLE) w_busy_nxt = 1'b1;
    if (w_state_nxt == S_DONE) w_done_nxt = 1'b1;
    if (w_state_nxt == S_RUN)  w_sel_nxt  = SEL_ADD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_alu_sel <= SEL_AND;
    end else begin
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_alu_sel <= w_sel_nxt;
    end
  end

  // Product datapath: {HI,LO} shifts right one bit per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
`ifdef MULT_SIGNED_EN
      r_sign  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= w_cap_a;
            r_lo    <= w_cap_b;
            r_hi    <= '0;
            r_cnt   <= '0;
`ifdef MULT_SIGNED_EN
            r_sign  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          r_hi  <= {w_carry, w_sum[WIDTH-1:1]};
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
`ifdef MULT_SIGNED_EN
        S_FIXUP: begin
          if (r_sign) {r_hi, r_lo} <= w_neg;
        end
`endif
        default: begin
          r_hi <= r_hi;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign alu_a   = r_hi;
  assign alu_b   = r_mcand;
  assign alu_sel = r_alu_sel;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Scoreboard bench for alu_mult_seq with a behavioural ALU and a plain-arithmetic product model.
module tb_alu_mult_seq;

  localparam int unsigned WIDTH = 32;
`ifdef MULT_SIGNED_EN
  localparam int LAT = WIDTH + 1;
`else
  localparam int LAT = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;

  typedef struct {
    logic [63:0] prod;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   run_cnt = 0;

  alu_mult_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared ALU stand-in
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
    logic [63:0] sa = {{32{a[31]}}, a};
    logic [63:0] sb = {{32{b[31]}}, b};
    return sa * sb;
`else
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    return ua * ub;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the oldest expectation on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      run_cnt = 0;
    end else begin
      if (busy && alu_sel == 3'b010) run_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 with no pending op at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("product", {hi, lo}, e.prod);
          chk("latency", 64'(cyc), 64'(e.done_cyc));
          chk("add_cycles", 64'(run_cnt), 64'(WIDTH));
        end
        run_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
      return;
    end
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    e.prod     = model(a, b);
    e.done_cyc = cyc + 1 + LAT;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d ops still pending", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_sel", 64'(alu_sel), 64'd0);
    chk("rst_alub", 64'(alu_b), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    issue(32'd3, 32'd5);
    drain();
    chk("hold_hilo", {hi, lo}, 64'd15);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(32'h1234_5678, 32'h0);
    issue(32'h0, 32'h8765_4321);
    issue(32'hFFFF_FFFE, 32'd3);
    issue(32'h8000_0000, 32'h8000_0000);
    issue(32'h7FFF_FFFF, 32'h8000_0001);
    drain();

    // Start re-asserted mid-RUN must be ignored
    issue(32'd3, 32'd5);
    repeat (9) @(negedge clk);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_sel", 64'(alu_sel), 64'd2);
    op_a  = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset in the middle of RUN
    issue(32'hDEAD_BEEF, 32'h0000_1234);
    repeat (15) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    chk("abort_sel", 64'(alu_sel), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_done", 64'(done), 64'd0);
    issue(32'd9, 32'd11);
    drain();

    // Random back-to-back traffic
    for (int i = 0; i < 20; i++) begin
      issue($urandom, $urandom);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
